// File: rtl/a_input_streamer_pkg.sv
// ============================================================================
// a_input_streamer_pkg: shared mode encodings, FSM states and config record.
// Revision: 1.0
// ============================================================================
`default_nettype none

package a_input_streamer_pkg;

   localparam int DATA_W_DEFAULT = 66;

   localparam logic [1:0] MODE_TRAIN = 2'd0;
   localparam logic [1:0] MODE_SWEEP = 2'd1;
   localparam logic [1:0] MODE_INF   = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_STREAM = 3'd2,
      ST_NEXT   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   typedef struct packed {
      logic [1:0]  mode;
      logic [15:0] train_epochs;
      logic [15:0] inf_epochs;
   } cfg_t;

endpackage

`default_nettype wire

// File: rtl/a_stream_skid.sv
// ============================================================================
// a_stream_skid: one-entry valid/ready output register feeding the ASIC link.
// Revision: 1.0
// ============================================================================
`default_nettype none

module a_stream_skid
   import a_input_streamer_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ready_i,
   output logic              accept_o,
   output logic              xfer_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              w_xfer;

   assign w_xfer   = valid_q & ready_i;
   assign accept_o = ~valid_q | ready_i;
   assign xfer_o   = w_xfer;
   assign valid_o  = valid_q;
   assign data_o   = data_q;

   // Data is zeroed when the entry drains so the link reads 0 while idle.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (w_xfer) begin
         valid_d = 1'b0;
         data_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/a_input_streamer.sv
// ============================================================================
// a_input_streamer: sequences training/inference epochs and streams FIFO words.
// Revision: 1.0
// ============================================================================
`default_nettype none

module a_input_streamer
   import a_input_streamer_pkg::*;
#(
   parameter int DATA_W          = DATA_W_DEFAULT,
   parameter int ASIC_RST_CYCLES = 16
) (
   input  logic              clk_a_domain,
   input  logic              reset,
   input  logic              cfg_valid,
   input  logic [1:0]        cfg_asic_mode,
   input  logic [15:0]       cfg_training_epochs,
   input  logic [15:0]       cfg_inference_epochs,
   output logic              fifo_d2a_data_rd_en,
   input  logic [DATA_W-1:0] fifo_d2a_data_dout,
   input  logic              fifo_d2a_data_empty,
   input  logic              fifo_d2a_data_valid,
   output logic              reset_n_from_fpga_to_asic,
   output logic              input_streaming_valid_from_fpga_to_asic,
   output logic [DATA_W-1:0] input_streaming_data_from_fpga_to_asic,
   input  logic              input_streaming_ready_from_asic_to_fpga,
   output logic              start_training_signal_from_fpga_to_asic,
   output logic              start_inference_signal_from_fpga_to_asic,
   input  logic              start_ready_from_asic_to_fpga,
   input  logic              inferenced_label_from_asic_to_fpga,
   output logic              busy,
   output logic              run_done,
   output logic              inf_label_valid,
   output logic              inf_label
);

   localparam int RST_CNT_W = (ASIC_RST_CYCLES > 2) ? $clog2(ASIC_RST_CYCLES) : 1;
   localparam logic [RST_CNT_W-1:0] c_RST_LAST =
      RST_CNT_W'((ASIC_RST_CYCLES > 0) ? ASIC_RST_CYCLES - 1 : 0);

   state_e              state_q, state_d;
   cfg_t                cfg_q, cfg_d;
   logic [15:0]         train_cnt_q, train_cnt_d;
   logic [15:0]         inf_cnt_q, inf_cnt_d;
   logic                is_inf_q, is_inf_d;
   logic                eoe_loaded_q, eoe_loaded_d;
   logic                start_train_q, start_train_d;
   logic                start_inf_q, start_inf_d;
   logic                busy_q, busy_d;
   logic                run_done_q, run_done_d;
   logic                inf_label_valid_q, inf_label_valid_d;
   logic                inf_label_q, inf_label_d;
   logic                label_q;
   logic [RST_CNT_W-1:0] rst_cnt_q;
   logic                asic_rstn_q;

   logic                w_rd_en;
   logic                w_accept;
   logic                w_xfer;
   logic                w_eoe_xfer;
   logic                w_skid_valid;
   logic [DATA_W-1:0]   w_skid_data;

   // ASIC reset hold-off; configuration is refused until the ASIC is out of reset.
   always_ff @(posedge clk_a_domain or posedge reset) begin
      if (reset) begin
         rst_cnt_q   <= '0;
         asic_rstn_q <= 1'b0;
      end else if (!asic_rstn_q) begin
         if (rst_cnt_q == c_RST_LAST) begin
            asic_rstn_q <= 1'b1;
         end else begin
            rst_cnt_q <= rst_cnt_q + RST_CNT_W'(1);
         end
      end
   end

   // Once the end-of-epoch word is buffered, popping stops until the next epoch.
   assign w_rd_en = (state_q == ST_STREAM) && !eoe_loaded_q && fifo_d2a_data_valid &&
                    !fifo_d2a_data_empty && w_accept;
   assign w_eoe_xfer = (state_q == ST_STREAM) && w_xfer && w_skid_data[DATA_W-1];

   a_stream_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk      (clk_a_domain),
      .rst      (reset),
      .load_i   (w_rd_en),
      .data_i   (fifo_d2a_data_dout),
      .ready_i  (input_streaming_ready_from_asic_to_fpga),
      .accept_o (w_accept),
      .xfer_o   (w_xfer),
      .valid_o  (w_skid_valid),
      .data_o   (w_skid_data)
   );

   always_comb begin
      state_d           = state_q;
      cfg_d             = cfg_q;
      train_cnt_d       = train_cnt_q;
      inf_cnt_d         = inf_cnt_q;
      is_inf_d          = is_inf_q;
      eoe_loaded_d      = eoe_loaded_q;
      inf_label_valid_d = 1'b0;
      inf_label_d       = inf_label_q;

      case (state_q)
         ST_IDLE: begin
            if (cfg_valid && asic_rstn_q) begin
               cfg_d.mode         = cfg_asic_mode;
               cfg_d.train_epochs = cfg_training_epochs;
               cfg_d.inf_epochs   = cfg_inference_epochs;
               train_cnt_d        = 16'd0;
               inf_cnt_d          = 16'd0;
               state_d            = ST_NEXT;
            end
         end
         ST_NEXT: begin
            eoe_loaded_d = 1'b0;
            state_d      = ST_DONE;
            case (cfg_q.mode)
               MODE_TRAIN: begin
                  if (train_cnt_q < cfg_q.train_epochs) begin
                     is_inf_d = 1'b0;
                     state_d  = ST_START;
                  end
               end
               MODE_INF: begin
                  if (inf_cnt_q < cfg_q.inf_epochs) begin
                     is_inf_d = 1'b1;
                     state_d  = ST_START;
                  end
               end
               MODE_SWEEP: begin
                  // Equal counts mean the pair is complete: begin another training epoch.
                  if (train_cnt_q != inf_cnt_q) begin
                     is_inf_d = 1'b1;
                     state_d  = ST_START;
                  end else if (train_cnt_q < cfg_q.train_epochs) begin
                     is_inf_d = 1'b0;
                     state_d  = ST_START;
                  end
               end
               default: state_d = ST_DONE;
            endcase
         end
         ST_START: begin
            if (start_ready_from_asic_to_fpga) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (w_rd_en && fifo_d2a_data_dout[DATA_W-1]) begin
               eoe_loaded_d = 1'b1;
            end
            if (w_eoe_xfer) begin
               if (is_inf_q) begin
                  inf_cnt_d         = inf_cnt_q + 16'd1;
                  inf_label_valid_d = 1'b1;
                  inf_label_d       = label_q;
               end else begin
                  train_cnt_d = train_cnt_q + 16'd1;
               end
               state_d = ST_NEXT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      start_train_d = (state_d == ST_START) && !is_inf_d;
      start_inf_d   = (state_d == ST_START) && is_inf_d;
      busy_d        = (state_d != ST_IDLE);
      run_done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_a_domain or posedge reset) begin
      if (reset) begin
         state_q           <= ST_IDLE;
         cfg_q             <= '0;
         train_cnt_q       <= 16'd0;
         inf_cnt_q         <= 16'd0;
         is_inf_q          <= 1'b0;
         eoe_loaded_q      <= 1'b0;
         start_train_q     <= 1'b0;
         start_inf_q       <= 1'b0;
         busy_q            <= 1'b0;
         run_done_q        <= 1'b0;
         inf_label_valid_q <= 1'b0;
         inf_label_q       <= 1'b0;
         label_q           <= 1'b0;
      end else begin
         state_q           <= state_d;
         cfg_q             <= cfg_d;
         train_cnt_q       <= train_cnt_d;
         inf_cnt_q         <= inf_cnt_d;
         is_inf_q          <= is_inf_d;
         eoe_loaded_q      <= eoe_loaded_d;
         start_train_q     <= start_train_d;
         start_inf_q       <= start_inf_d;
         busy_q            <= busy_d;
         run_done_q        <= run_done_d;
         inf_label_valid_q <= inf_label_valid_d;
         inf_label_q       <= inf_label_d;
         label_q           <= inferenced_label_from_asic_to_fpga;
      end
   end

   assign fifo_d2a_data_rd_en                      = w_rd_en;
   assign reset_n_from_fpga_to_asic                = asic_rstn_q;
   assign input_streaming_valid_from_fpga_to_asic  = w_skid_valid;
   assign input_streaming_data_from_fpga_to_asic   = w_skid_data;
   assign start_training_signal_from_fpga_to_asic  = start_train_q;
   assign start_inference_signal_from_fpga_to_asic = start_inf_q;
   assign busy                                     = busy_q;
   assign run_done                                 = run_done_q;
   assign inf_label_valid                          = inf_label_valid_q;
   assign inf_label                                = inf_label_q;

endmodule

`default_nettype wire
